// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared next-PC macros, state encodings and constants for the PC redirect controller.
// The macro block is guarded so it may be seen by several compilation units.
`ifndef PC_REDIRECT_DEFINES
`define PC_REDIRECT_DEFINES
`define PC_BUS        16
`define PC_JUMP       1'b1
`define PC_ADD        1'b0
`define PC_ST_RUN     1'b0
`define PC_ST_PENDING 1'b1
`endif

package pc_redirect_ctrl_pkg;

  localparam int   PC_BUS_W = `PC_BUS;
  localparam logic OP_JUMP  = `PC_JUMP;
  localparam logic OP_ADD   = `PC_ADD;

  typedef enum logic {
    ST_RUN     = `PC_ST_RUN,
    ST_PENDING = `PC_ST_PENDING
  } state_e;

endpackage

// File: rtl/PC_JUMP_MUX.sv
// Next-PC select: redirect target when the op is JUMP, sequential PC otherwise.
// Purely combinational.
module PC_JUMP_MUX
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int W = PC_BUS_W
) (
  input  logic         PC_jump_op,
  input  logic [W-1:0] PC_add,
  input  logic [W-1:0] PC_jump,
  output logic [W-1:0] PC_new
);

  assign PC_new = (PC_jump_op == OP_JUMP) ? PC_jump : PC_add;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC register with redirect handling: a redirect blocked by fetch_ready is parked
// in PENDING and applied on the first accepted fetch; stall only holds sequential advance.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int                  PC_WIDTH  = PC_BUS_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  PC_STEP   = 1,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_ready,
  input  logic                 stall,
  input  logic                 jump_valid,
  input  logic [PC_WIDTH-1:0]  jump_target,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [PC_WIDTH-1:0]  PC_add,
  output logic [PC_WIDTH-1:0]  PC_jump,
  output logic                 PC_jump_op,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] redirect_cnt
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  r_pend_tgt;
  logic                 r_flush;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_jump_op;
  logic [PC_WIDTH-1:0]  w_pc_jump;
  logic [PC_WIDTH-1:0]  w_pc_add;
  logic [PC_WIDTH-1:0]  w_pc_new;
  logic                 w_pc_load;
  logic                 w_redir_load;
  logic                 w_accept;
  logic                 w_capture;

  assign w_pc_add  = r_pc + PC_WIDTH'(PC_STEP);
  assign w_pc_jump = (r_state == ST_PENDING) ? r_pend_tgt : jump_target;

  always_comb begin
    w_state_nxt  = r_state;
    w_jump_op    = OP_ADD;
    w_pc_load    = 1'b0;
    w_redir_load = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (jump_valid) begin
          w_accept = 1'b1;
          if (fetch_ready) begin
            w_jump_op    = OP_JUMP;
            w_pc_load    = 1'b1;
            w_redir_load = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_PENDING;
          end
        end else if (fetch_ready && !stall) begin
          w_pc_load = 1'b1;
        end
      end
      ST_PENDING: begin
        // New redirects are ignored here: the parked one is older and wins.
        if (fetch_ready) begin
          w_jump_op    = OP_JUMP;
          w_pc_load    = 1'b1;
          w_redir_load = 1'b1;
          w_state_nxt  = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  PC_JUMP_MUX #(
    .W (PC_WIDTH)
  ) u_jump_mux (
    .PC_jump_op (w_jump_op),
    .PC_add     (w_pc_add),
    .PC_jump    (w_pc_jump),
    .PC_new     (w_pc_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_pend_tgt <= '0;
      r_flush    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_accept;
      if (w_pc_load)
        r_pc <= w_pc_new;
      if (w_capture)
        r_pend_tgt <= jump_target;
      if (w_redir_load && (r_cnt != {CNT_WIDTH{1'b1}}))
        r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign PC           = r_pc;
  assign PC_add       = w_pc_add;
  assign PC_jump      = w_pc_jump;
  assign PC_jump_op   = w_jump_op;
  assign flush        = r_flush;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: two instances (default, and wrap/saturation params)
// checked each cycle against a behavioural model, plus literal expectations.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, fetch_ready, stall, jump_valid;
  logic [15:0] jump_target;

  logic [15:0] a_pc, a_add, a_jump, a_cnt;
  logic        a_op, a_flush;
  logic [15:0] b_pc, b_add, b_jump;
  logic [1:0]  b_cnt;
  logic        b_op, b_flush;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state, one slot per instance
  logic [15:0] m_pc   [2];
  logic [15:0] m_tgt  [2];
  bit          m_pv   [2];
  bit          m_flush[2];
  int          m_cnt  [2];
  int          cnt_max[2] = '{65535, 3};
  logic [15:0] rst_pc [2] = '{16'h0000, 16'hFFFF};

  always #5 clk = ~clk;

  pc_redirect_ctrl u_a (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .PC(a_pc), .PC_add(a_add), .PC_jump(a_jump), .PC_jump_op(a_op),
    .flush(a_flush), .redirect_cnt(a_cnt)
  );

  pc_redirect_ctrl #(.RESET_PC(16'hFFFF), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .PC(b_pc), .PC_add(b_add), .PC_jump(b_jump), .PC_jump_op(b_op),
    .flush(b_flush), .redirect_cnt(b_cnt)
  );

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit applied, accepted;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pc[i] = rst_pc[i]; m_pv[i] = 1'b0; m_tgt[i] = '0;
        m_flush[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        applied = 1'b0; accepted = 1'b0;
        if (m_pv[i]) begin
          if (fetch_ready) begin
            m_pc[i] = m_tgt[i]; m_pv[i] = 1'b0; applied = 1'b1;
          end
        end else if (jump_valid) begin
          accepted = 1'b1;
          if (fetch_ready) begin
            m_pc[i] = jump_target; applied = 1'b1;
          end else begin
            m_pv[i] = 1'b1; m_tgt[i] = jump_target;
          end
        end else if (fetch_ready && !stall) begin
          m_pc[i] = m_pc[i] + 16'd1;
        end
        m_flush[i] = accepted;
        if (applied && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] e_add;
        e_add = m_pc[i] + 16'd1;
        chk(i == 0 ? "a.PC" : "b.PC", i == 0 ? a_pc : b_pc, m_pc[i]);
        chk(i == 0 ? "a.PC_add" : "b.PC_add", i == 0 ? a_add : b_add, e_add);
        chk(i == 0 ? "a.PC_jump" : "b.PC_jump", i == 0 ? a_jump : b_jump,
            m_pv[i] ? m_tgt[i] : jump_target);
        chk(i == 0 ? "a.op" : "b.op", i == 0 ? a_op : b_op,
            m_pv[i] ? fetch_ready : (jump_valid && fetch_ready));
        chk(i == 0 ? "a.flush" : "b.flush", i == 0 ? a_flush : b_flush, m_flush[i]);
        chk(i == 0 ? "a.cnt" : "b.cnt", i == 0 ? a_cnt : 16'(b_cnt), m_cnt[i]);
      end
    end
  end

  task automatic drv(input bit r, input bit fr, input bit st, input bit jv, input logic [15:0] jt);
    rst = r; fetch_ready = fr; stall = st; jump_valid = jv; jump_target = jt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1, 0, 0, 0, 16'h0);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_pc_a", a_pc, 16'h0000);
    chk("rst_pc_b", b_pc, 16'hFFFF);
    chk("rst_op", a_op, 0);
    chk("rst_flush", a_flush, 0);
    chk("rst_cnt", a_cnt, 0);

    // Sequential run
    for (int k = 1; k <= 4; k++) begin
      drv(0, 1, 0, 0, 16'h0);
      tick();
      chk("seq_pc", a_pc, k);
      chk("seq_flush", a_flush, 0);
      if (k == 1) chk("wrap_pc_b", b_pc, 16'h0000);
    end
    chk("seq_cnt", a_cnt, 0);
    drv(0, 1, 0, 0, 16'h0);
    tick();
    chk("pc_5", a_pc, 16'h0005);

    // Immediate redirect
    drv(0, 1, 0, 1, 16'h0040);
    #1;
    chk("imm_op", a_op, 1);
    chk("imm_jump", a_jump, 16'h0040);
    tick();
    chk("imm_pc", a_pc, 16'h0040);
    chk("imm_flush", a_flush, 1);
    chk("imm_cnt", a_cnt, 1);
    drv(0, 0, 0, 0, 16'h0);
    tick();
    chk("imm_flush_off", a_flush, 0);

    // Blocked redirect, later redirect ignored
    drv(0, 0, 0, 1, 16'h0080);
    tick();
    chk("blk_hold", a_pc, 16'h0040);
    chk("blk_flush", a_flush, 1);
    drv(0, 0, 0, 1, 16'h00F0);
    #1;
    chk("blk_pend_jump", a_jump, 16'h0080);
    tick();
    chk("blk_flush_once", a_flush, 0);
    drv(0, 0, 0, 0, 16'h0);
    tick();
    chk("blk_hold2", a_pc, 16'h0040);
    drv(0, 1, 0, 0, 16'h0);
    #1;
    chk("blk_apply_op", a_op, 1);
    tick();
    chk("blk_pc", a_pc, 16'h0080);
    chk("blk_no_reflush", a_flush, 0);
    chk("blk_cnt", a_cnt, 2);

    // Stall versus redirect
    drv(0, 1, 1, 0, 16'h0);
    tick();
    chk("stall_hold", a_pc, 16'h0080);
    drv(0, 1, 1, 1, 16'h0010);
    tick();
    chk("stall_redir", a_pc, 16'h0010);

    // Saturation on the 2-bit counter
    drv(0, 1, 0, 1, 16'h0020);
    tick();
    drv(0, 1, 0, 1, 16'h0030);
    tick();
    chk("cnt_a5", a_cnt, 5);
    chk("cnt_b_sat", b_cnt, 3);

    // Reset while pending
    drv(0, 0, 0, 1, 16'h0123);
    tick();
    drv(1, 1, 0, 0, 16'h0);
    tick();
    chk("rstp_pc", a_pc, 16'h0000);
    chk("rstp_flush", a_flush, 0);
    chk("rstp_op", a_op, 0);
    drv(0, 1, 0, 0, 16'h0);
    tick();
    chk("rstp_discard", a_pc, 16'h0001);
    chk("rstp_cnt", a_cnt, 0);

    // Mixed patterned traffic, checked by the model
    for (int i = 0; i < 60; i++) begin
      drv(0, (i % 4) != 1, (i % 5) == 2, (i % 7) == 3, 16'(i * 37));
      tick();
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
